// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and imem.
// The master side is the fetch unit. The slave side is the memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the main control decoder.
// Owns the PC. It fetches one 32-bit word per instruction over a req/ack port and
// holds that word until the datapath retires it. On retire it selects the next PC
// from the jump, branch and sequential candidates.
// Optional build macro FETCH_PERF_CNT_EN adds saturating retire and fetch-stall
// counters.
//
// state | meaning
// BOOT  | first cycle out of reset, no request issued
// FETCH | imem_req high at imem_addr=pc, waiting for imem_ack
// EXEC  | instr valid, waiting for retire to advance pc
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PERF_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       imem,
    output logic [31:0]        pc,
    output logic [31:0]        instr,
    output logic [5:0]         ins_H,
    output logic [5:0]         ins_L,
    output logic               instr_valid,
    input  logic               retire,
    input  logic               Branch,
    input  logic               PCSrc,
    input  logic               zero
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]  retired_cnt,
    output logic [PERF_W-1:0]  fetch_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc4, br_off, next_pc;
    logic        accept_ack, accept_retire;

    // Elaboration-time sanity checks on the parameters.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_unit: RESET_PC must be word aligned");
    end
    if (PERF_W < 1) begin : g_bad_perf_w
        $error("fetch_unit: PERF_W must be at least 1");
    end

    assign accept_ack    = (state == FETCH) && imem.imem_ack;
    assign accept_retire = (state == EXEC) && retire;

    // State register. Reset also drops imem_req asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   if (imem.imem_ack) state_nxt = EXEC;
            EXEC:    if (retire) state_nxt = FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        case (state)
            FETCH:   imem.imem_req = 1'b1;
            EXEC:    instr_valid   = 1'b1;
            default: ;
        endcase
    end

    // Next-PC selection. A jump has priority over a taken branch, and all sums wrap modulo 2^32.
    always_comb begin
        pc4    = pc + 32'd4;
        br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (PCSrc)              next_pc = {pc4[31:28], instr[25:0], 2'b00};
        else if (Branch && zero) next_pc = pc4 + br_off;
        else                    next_pc = pc4;
    end

    // The PC and instruction registers are only written at the two handshake points.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            instr <= 32'h0000_0000;
        end else begin
            if (accept_retire) pc    <= next_pc;
            if (accept_ack)    instr <= imem.imem_rdata;
        end
    end

    assign imem.imem_addr = pc;
    assign ins_H          = instr[31:26];
    assign ins_L          = instr[5:0];

`ifdef FETCH_PERF_CNT_EN
    // Saturating performance counters: accepted retires, and stalled fetch cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt    <= '0;
            fetch_wait_cnt <= '0;
        end else begin
            if (accept_retire && (retired_cnt != '1))
                retired_cnt <= retired_cnt + 1'b1;
            if ((state == FETCH) && !imem.imem_ack && (fetch_wait_cnt != '1))
                fetch_wait_cnt <= fetch_wait_cnt + 1'b1;
        end
    end
`endif

endmodule
